// File: rtl/dog_align_diff.sv
// dog_align_diff: difference-of-Gaussian back end for one octave.
// Each of the first NUM_SCALES-1 Gaussian streams passes through its own
// ALIGN_DELAY-deep delay line, which advances only on that stream's valid
// beats. Difference k = (delayed stream k - live stream k+1) << DIFF_SHIFT.
// The result is either clamped to a signed byte (SIGNED_OUT=1) or truncated
// to its low 8 bits (SIGNED_OUT=0). Outputs are registered one cycle after
// the stream k+1 beat.
// Optional feature, macro DOG_SAT_COUNT_EN: adds a 16-bit sat_count output.
// It counts the cycles in which any qualified lane overflowed 8 bits.
module dog_align_diff #(
   parameter int NUM_SCALES  = 5,
   parameter int ALIGN_DELAY = 642,
   parameter int DIFF_SHIFT  = 3,
   parameter int SIGNED_OUT  = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_SCALES*8-1:0]       g_data,
   input  logic [NUM_SCALES-1:0]         g_valid,
   input  logic [NUM_SCALES-1:0]         g_blank,
   output logic [(NUM_SCALES-1)*8-1:0]   d_dout,
   output logic [NUM_SCALES-2:0]         d_valid,
   output logic [NUM_SCALES-2:0]         d_blank,
   output logic [NUM_SCALES-2:0]         primed
`ifdef DOG_SAT_COUNT_EN
   ,
   output logic [15:0]                   sat_count
`endif
);

   // Number of difference lanes / delay lines.
   localparam int NL = NUM_SCALES - 1;
   // Write pointer width; a depth of 1 still needs a 1-bit pointer.
   localparam int AW = (ALIGN_DELAY > 1) ? $clog2(ALIGN_DELAY) : 1;
   // Fill counter saturates at ALIGN_DELAY+1 and must hold that value.
   localparam int FW = $clog2(ALIGN_DELAY + 2);
   // Shifted difference width: the full 9-bit difference plus the shift.
   localparam int SW = 9 + DIFF_SHIFT;

   localparam logic [AW-1:0] WP_LAST  = AW'(ALIGN_DELAY - 1);
   localparam logic [FW-1:0] FILL_ARM = FW'(ALIGN_DELAY);
   localparam logic [FW-1:0] FILL_MAX = FW'(ALIGN_DELAY + 1);

   // Blanking of stream 0 never accompanies a difference output.
   logic w_unused_blank0;
   assign w_unused_blank0 = g_blank[0];

`ifdef DOG_SAT_COUNT_EN
   // Per-lane overflow on a beat that produces a valid difference.
   logic [NL-1:0] w_lane_sat;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NL; gi++) begin : g_lane
         // Delay line storage; contents are never cleared, and priming
         // guarantees that stale entries never reach a valid output.
         logic [7:0]    r_mem [0:ALIGN_DELAY-1];
         logic [AW-1:0] r_wp;
         logic [7:0]    r_dly_q;
         logic [FW-1:0] r_fill;
         logic          r_primed;
         logic [7:0]    r_dout;
         logic          r_valid;
         logic          r_blank;

         logic [7:0]           w_in_k;
         logic [7:0]           w_in_next;
         logic signed [8:0]    w_raw;
         logic signed [SW-1:0] w_shifted;
         logic                 w_ovf;
         logic [7:0]           w_result;

         assign w_in_k    = g_data[gi*8 +: 8];
         assign w_in_next = g_data[(gi+1)*8 +: 8];

         // Delay memory write; the old entry is read in the same beat below.
         always_ff @(posedge clock) begin
            if (g_valid[gi]) begin
               r_mem[r_wp] <= w_in_k;
            end
         end

         // Registered read of the entry about to be overwritten, plus pointer.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_dly_q <= 8'd0;
               r_wp    <= '0;
            end else if (g_valid[gi]) begin
               r_dly_q <= r_mem[r_wp];
               r_wp    <= (r_wp == WP_LAST) ? '0 : r_wp + 1'b1;
            end
         end

         // Count beats until the delay line has produced a real sample.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_fill   <= '0;
               r_primed <= 1'b0;
            end else if (g_valid[gi]) begin
               if (r_fill != FILL_MAX) begin
                  r_fill <= r_fill + 1'b1;
               end
               if (r_fill == FILL_ARM) begin
                  r_primed <= 1'b1;
               end
            end
         end

         // Difference, lossless shift and 8-bit output mapping.
         always_comb begin
            w_raw     = $signed({1'b0, r_dly_q}) - $signed({1'b0, w_in_next});
            w_shifted = SW'(w_raw) <<< DIFF_SHIFT;
            // Overflow whenever bits [SW-1:7] are not a pure sign extension.
            w_ovf     = ~((&w_shifted[SW-1:7]) | ~(|w_shifted[SW-1:7]));
            if ((SIGNED_OUT != 0) && w_ovf) begin
               w_result = w_shifted[SW-1] ? 8'h80 : 8'h7F;
            end else begin
               w_result = w_shifted[7:0];
            end
         end

         // Output register: data and blank hold between beats, valid is a strobe.
         always_ff @(posedge clock) begin
            if (reset) begin
               r_dout  <= 8'd0;
               r_valid <= 1'b0;
               r_blank <= 1'b0;
            end else begin
               r_valid <= 1'b0;
               if (g_valid[gi+1]) begin
                  r_dout  <= w_result;
                  r_blank <= g_blank[gi+1];
                  r_valid <= r_primed & ~g_blank[gi+1];
               end
            end
         end

         assign d_dout[gi*8 +: 8] = r_dout;
         assign d_valid[gi]       = r_valid;
         assign d_blank[gi]       = r_blank;
         assign primed[gi]        = r_primed;

`ifdef DOG_SAT_COUNT_EN
         assign w_lane_sat[gi] = g_valid[gi+1] & r_primed & ~g_blank[gi+1] & w_ovf;
`endif
      end
   endgenerate

`ifdef DOG_SAT_COUNT_EN
   logic        r_last_blank;
   logic [15:0] r_sat_count;
   logic        w_blank_rise;

   // Start of blanking is judged on valid beats of the last stream.
   assign w_blank_rise = g_valid[NL] & g_blank[NL] & ~r_last_blank;

   // Saturating per-cycle overflow counter, cleared at the start of blanking.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_blank <= 1'b0;
         r_sat_count  <= 16'd0;
      end else begin
         if (g_valid[NL]) begin
            r_last_blank <= g_blank[NL];
         end
         if (w_blank_rise) begin
            r_sat_count <= 16'd0;
         end else if ((|w_lane_sat) && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
         end
      end
   end

   assign sat_count = r_sat_count;
`endif

endmodule
